// File: rtl/prog_mem_arb_pkg.sv
// rtl/prog_mem_arb_pkg.sv - shared encodings and memory-map constants for the program memory arbiter
package prog_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    WRITE     = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_LDR = 1'b1
  } port_e;

  // Boot ROM window, also used by the memory map decoder
  localparam logic [15:0] DEF_ROM_BASE  = 16'h2000;
  localparam int          DEF_ROM_WORDS = 1024;

endpackage

// File: rtl/prog_mem_arbiter.sv
// rtl/prog_mem_arbiter.sv - round-robin arbiter sharing the program memory port between CPU and loader
// Loader hold mode gives the loader strict priority; writes into the boot ROM window are dropped and flagged.
module prog_mem_arbiter
  import prog_mem_arb_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    READ_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] ROM_BASE     = ADDR_WIDTH'(DEF_ROM_BASE),
  parameter int                    ROM_WORDS    = DEF_ROM_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_stall,
  input  logic                  ldr_req,
  input  logic                  ldr_wr,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  output logic                  ldr_ack,
  input  logic                  ldr_hold,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rom_wr_err
);

  // One extra bit so a window ending at the top of the address space does not wrap
  localparam logic [ADDR_WIDTH:0] ROM_END  = {1'b0, ROM_BASE} + (ADDR_WIDTH+1)'(ROM_WORDS);
  localparam logic [1:0]          LAT_LAST = 2'(READ_LATENCY);

  arb_state_e            state, state_nxt;
  port_e                 last_grant, last_nxt;
  port_e                 gnt_port, port_nxt;
  port_e                 g_port;
  logic [1:0]            cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic                  we_nxt, re_nxt, err_nxt;
  logic                  cpu_ack_nxt, ldr_ack_nxt;
  logic [DATA_WIDTH-1:0] cpu_rdata_nxt, ldr_rdata_nxt;
  logic                  cpu_elig, ldr_elig;
  logic                  g_wr;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;

  function automatic logic in_rom(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= {1'b0, ROM_BASE}) && ({1'b0, a} < ROM_END);
  endfunction

  // A port whose ack is high this cycle sits out one arbitration (turnaround)
  assign cpu_elig  = cpu_req & ~ldr_hold & ~cpu_ack;
  assign ldr_elig  = ldr_req & ~ldr_ack;
  assign cpu_stall = ldr_hold & cpu_req;

  always_comb begin
    state_nxt     = state;
    last_nxt      = last_grant;
    port_nxt      = gnt_port;
    cnt_nxt       = cnt;
    addr_nxt      = mem_addr;
    wdata_nxt     = mem_wdata;
    we_nxt        = 1'b0;
    re_nxt        = 1'b0;
    err_nxt       = 1'b0;
    cpu_ack_nxt   = 1'b0;
    ldr_ack_nxt   = 1'b0;
    cpu_rdata_nxt = cpu_rdata;
    ldr_rdata_nxt = ldr_rdata;

    if (cpu_elig && ldr_elig) begin
      g_port = (last_grant == PORT_CPU) ? PORT_LDR : PORT_CPU;
    end else if (ldr_elig) begin
      g_port = PORT_LDR;
    end else begin
      g_port = PORT_CPU;
    end
    g_wr    = (g_port == PORT_LDR) ? ldr_wr    : cpu_wr;
    g_addr  = (g_port == PORT_LDR) ? ldr_addr  : cpu_addr;
    g_wdata = (g_port == PORT_LDR) ? ldr_wdata : cpu_wdata;

    case (state)
      IDLE: begin
        if (cpu_elig || ldr_elig) begin
          port_nxt = g_port;
          last_nxt = g_port;
          addr_nxt = g_addr;
          cnt_nxt  = '0;
          if (!g_wr) begin
            re_nxt    = 1'b1;
            state_nxt = READ_WAIT;
          end else begin
            wdata_nxt = g_wdata;
            state_nxt = WRITE;
            if (in_rom(g_addr)) begin
              err_nxt = 1'b1;
            end else begin
              we_nxt = 1'b1;
            end
          end
        end
      end

      READ_WAIT: begin
        if (cnt == LAT_LAST) begin
          state_nxt = IDLE;
          if (gnt_port == PORT_LDR) begin
            ldr_rdata_nxt = mem_rdata;
            ldr_ack_nxt   = 1'b1;
          end else begin
            cpu_rdata_nxt = mem_rdata;
            cpu_ack_nxt   = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end

      WRITE: begin
        state_nxt = IDLE;
        if (gnt_port == PORT_LDR) begin
          ldr_ack_nxt = 1'b1;
        end else begin
          cpu_ack_nxt = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_LDR;
      gnt_port   <= PORT_CPU;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      rom_wr_err <= 1'b0;
      cpu_ack    <= 1'b0;
      ldr_ack    <= 1'b0;
      cpu_rdata  <= '0;
      ldr_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_nxt;
      gnt_port   <= port_nxt;
      cnt        <= cnt_nxt;
      mem_addr   <= addr_nxt;
      mem_wdata  <= wdata_nxt;
      mem_we     <= we_nxt;
      mem_re     <= re_nxt;
      rom_wr_err <= err_nxt;
      cpu_ack    <= cpu_ack_nxt;
      ldr_ack    <= ldr_ack_nxt;
      cpu_rdata  <= cpu_rdata_nxt;
      ldr_rdata  <= ldr_rdata_nxt;
    end
  end

endmodule
